// File: rtl/apb_modport_if.sv
// apb_modport_if: APB3 bus bundle between a requester (master) and the apb_modport completer (slave).
// The _i/_o suffixes name directions as seen from the completer.
interface apb_modport_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int WIDTH      = 32
);
    logic                  psel_i;
    logic                  penable_i;
    logic                  pwrite_i;
    logic [ADDR_WIDTH-1:0] paddr_i;
    logic [WIDTH-1:0]      pwdata_i;
    logic [WIDTH-1:0]      prdata_o;
    logic                  pready_o;
    logic                  pslverr_o;

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/apb_modport.sv
// apb_modport: APB3 completer backed by a DEPTH-word register file that clears on reset.
// Define APB_WAIT_STATE_EN to add WAIT_CYCLES wait states to every access phase.
module apb_modport #(
`ifdef APB_WAIT_STATE_EN
    parameter int WAIT_CYCLES = 2,
`endif
    parameter int ADDR_WIDTH = 8,
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 64
) (
    input  logic         pclk_i,
    input  logic         presetn_i,
    apb_modport_if.slave apb
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state_q, state_d, cur_state;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [WIDTH-1:0]  prdata_q, prdata_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic              wr_en;
    logic              setup_err;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_write;
    logic              sel_err;
    logic [WIDTH-1:0]  rd_word;
`ifdef APB_WAIT_STATE_EN
    logic [3:0]        cnt_q, cnt_d;
`endif

    assign apb.pready_o  = pready_q;
    assign apb.pslverr_o = pslverr_q;
    assign apb.prdata_o  = prdata_q;

    assign setup_err = (64'(apb.paddr_i) >= 64'(DEPTH));

    // The setup phase is recognised from the live bus so the access cycle can already carry pready_o.
    always_comb begin
        cur_state = state_q;
        if (state_q == IDLE && apb.psel_i && !apb.penable_i) begin
            cur_state = SETUP;
        end
    end

    always_comb begin
        if (cur_state == SETUP) begin
            sel_idx   = apb.paddr_i[IDX_W-1:0];
            sel_write = apb.pwrite_i;
            sel_err   = setup_err;
        end else begin
            sel_idx   = idx_q;
            sel_write = write_q;
            sel_err   = err_q;
        end
        rd_word = '0;
        if (!sel_err && !sel_write) begin
            rd_word = mem_q[sel_idx];
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        write_d   = write_q;
        err_d     = err_q;
        wdata_d   = wdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        wr_en     = 1'b0;
`ifdef APB_WAIT_STATE_EN
        cnt_d     = cnt_q;
`endif
        case (cur_state)
            SETUP: begin
                state_d = ACCESS;
                idx_d   = apb.paddr_i[IDX_W-1:0];
                write_d = apb.pwrite_i;
                err_d   = setup_err;
                wdata_d = apb.pwdata_i;
`ifdef APB_WAIT_STATE_EN
                cnt_d     = 4'(WAIT_CYCLES);
                pready_d  = (WAIT_CYCLES == 0);
                pslverr_d = (WAIT_CYCLES == 0) && setup_err;
                prdata_d  = (WAIT_CYCLES == 0) ? rd_word : '0;
`else
                pready_d  = 1'b1;
                pslverr_d = setup_err;
                prdata_d  = rd_word;
`endif
            end
            ACCESS: begin
                if (!apb.psel_i) begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (pready_q) begin
                    if (apb.penable_i) begin
                        wr_en     = write_q && !err_q;
                        state_d   = IDLE;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        prdata_d  = '0;
                    end
                end
`ifdef APB_WAIT_STATE_EN
                else if (apb.penable_i) begin
                    if (cnt_q <= 4'd1) begin
                        cnt_d     = 4'd0;
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        prdata_d  = rd_word;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
`endif
            end
            default: begin
                state_d   = IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end
        endcase
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
`ifdef APB_WAIT_STATE_EN
            cnt_q     <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
`ifdef APB_WAIT_STATE_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Flop-based storage: every word must clear on reset, which block RAM cannot do.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        assign mem_d[gi] = (wr_en && idx_q == IDX_W'(gi)) ? wdata_q : mem_q[gi];

        always_ff @(posedge pclk_i or negedge presetn_i) begin
            if (!presetn_i) begin
                mem_q[gi] <= '0;
            end else begin
                mem_q[gi] <= mem_d[gi];
            end
        end
    end
endmodule

// File: tb/tb_apb_modport.sv
// tb_apb_modport: directed plus random APB transfers checked against an array model of the register file.
module tb_apb_modport;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
`ifdef APB_WAIT_STATE_EN
    localparam int EXP_WAIT = 2;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] ref_mem [DEPTH];

    apb_modport_if #(.ADDR_WIDTH(AW), .WIDTH(DW)) bus ();

    apb_modport #(.ADDR_WIDTH(AW), .WIDTH(DW), .DEPTH(DEPTH)) dut (
        .pclk_i    (clk),
        .presetn_i (rst_n),
        .apb       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rdy"}, 32'(bus.pready_o), 32'h0);
        chk({tag, "_err"}, 32'(bus.pslverr_o), 32'h0);
        chk({tag, "_rdata"}, bus.prdata_o, 32'h0);
    endtask

    task automatic idle(input int n);
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            chk("idle_rdy", 32'(bus.pready_o), 32'h0);
        end
    endtask

    // Entered #1 after a rising edge; leaves #1 after the completion edge so a
    // following call produces a back-to-back transfer.
    task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d);
        int          waits;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] got_rd;
        logic        got_err;
        exp_err = (a >= DEPTH);
        exp_rd  = (wr || exp_err) ? 32'h0 : ref_mem[a[5:0]];
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = wr;
        bus.paddr_i   = a;
        bus.pwdata_i  = d;
        @(posedge clk); #1;
        bus.penable_i = 1'b1;
        bus.paddr_i   = ~a;
        bus.pwdata_i  = ~d;
        bus.pwrite_i  = ~wr;
        waits = 0;
        while (bus.pready_o !== 1'b1 && waits < 20) begin
            chk("wait_rdata", bus.prdata_o, 32'h0);
            @(posedge clk); #1;
            waits++;
        end
        chk("wait_cycles", 32'(waits), 32'(EXP_WAIT));
        got_rd  = bus.prdata_o;
        got_err = bus.pslverr_o;
        chk("pslverr", 32'(got_err), 32'(exp_err));
        if (!wr) chk("prdata", got_rd, exp_rd);
        if (wr && !exp_err) ref_mem[a[5:0]] = d;
        $display("xfer %s addr=%02h wdata=%08h rdata=%08h err=%0d waits=%0d",
                 wr ? "WR" : "RD", a, d, got_rd, got_err, waits);
        @(posedge clk); #1;
        chk_quiet("drop");
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b0;
        bus.paddr_i   = '0;
        bus.pwdata_i  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst_n = 1'b1;
        idle(2);

        // Directed plan items
        xfer(1'b0, 8'h05, 32'h0);
        xfer(1'b1, 8'h10, 32'hDEADBEEF);
        idle(1);
        xfer(1'b0, 8'h10, 32'h0);
        xfer(1'b1, 8'h01, 32'h00000011);
        xfer(1'b1, 8'h02, 32'h00000022);
        xfer(1'b0, 8'h01, 32'h0);
        xfer(1'b0, 8'h02, 32'h0);
        idle(1);
        xfer(1'b1, 8'h40, 32'h12345678);
        xfer(1'b0, 8'h40, 32'h0);
        xfer(1'b1, 8'hFF, 32'h87654321);
        xfer(1'b1, 8'h3F, 32'h3F3F3F3F);
        xfer(1'b0, 8'h3F, 32'h0);
        xfer(1'b1, 8'h10, 32'hA5A5A5A5);
        xfer(1'b0, 8'h10, 32'h0);

        // penable without a setup phase must not start a transfer
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b1;
        bus.pwrite_i  = 1'b1;
        bus.paddr_i   = 8'h07;
        bus.pwdata_i  = 32'hBADBAD07;
        repeat (2) begin
            @(posedge clk); #1;
            chk("no_setup_rdy", 32'(bus.pready_o), 32'h0);
        end
        idle(1);
        xfer(1'b0, 8'h07, 32'h0);

        // psel dropped in the access phase aborts without writing
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b1;
        bus.paddr_i   = 8'h08;
        bus.pwdata_i  = 32'h0BAD0BAD;
        @(posedge clk); #1;
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b1;
        @(posedge clk); #1;
        chk_quiet("abort");
        idle(1);
        xfer(1'b0, 8'h08, 32'h0);

        // Reset during the access phase of a write
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b1;
        bus.paddr_i   = 8'h03;
        bus.pwdata_i  = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.penable_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_quiet("midrst");
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        idle(1);
        xfer(1'b0, 8'h03, 32'h0);
        xfer(1'b0, 8'h10, 32'h0);

        // Random traffic, mostly in a small window so reads hit earlier writes
        for (int n = 0; n < 120; n++) begin
            logic [7:0]  ra;
            logic        rw;
            if ($urandom_range(0, 5) == 0) ra = 8'($urandom_range(64, 255));
            else                           ra = 8'($urandom_range(0, 15));
            rw = 1'($urandom_range(0, 1));
            xfer(rw, ra, $urandom);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
